mem_io_responder: RTL and testbench

//  Target end of the CPU byte-wide memory bus: answers mem_a/mem_dout/mem_wr with mem_din.

---
 rtl/mem_io_pkg.sv | 10 +
 rtl/byte_fifo.sv | 41 ++++
 rtl/mem_io_responder.sv | 92 +++++++++
 tb/tb_mem_io_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared address map, RAM size and io-region decode for the CPU memory responder
package mem_io_pkg;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR = 18'h30004;
  localparam int RAM_AW_DEF = 17;
  localparam int RAM_BYTES = 1 << RAM_AW_DEF;
  function automatic logic is_io(input logic [17:0] a);
    return a[17:16] == 2'b11;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte FIFO whose head reads 0 when empty; overflowing pushes and underflowing pops are ignored
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? 8'h00 : mem[rd_ptr];
  // storage is not reset; the empty flag hides stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointers wrap at depth; push+pop together leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus target with RAM, UART FIFOs, cycle counter and program stop
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW = $clog2(RAM_BYTES),
  parameter int IN_DEPTH = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic        tx_ovf
);
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  logic [7:0] mem [2**RAM_AW];
  logic [17:0] a;
  logic io, wr_ok, rd_uart, rd_clk, wr_clk;
  logic in_pop, in_full, in_empty;
  logic [7:0] in_head;
  logic [ICW-1:0] unused_in_count;
  logic out_push, out_full, out_empty;
  logic [7:0] out_din, io_rd;
  logic [OCW-1:0] out_count;
  logic [31:0] counter;
  logic [23:0] snap;
  logic unused_hi;
  assign unused_hi = ^cpu_a[31:18];
  assign a = cpu_a[17:0];
  assign io = is_io(a);
  assign wr_ok = cpu_wr && !halted;
  assign rd_uart = !cpu_wr && a == IO_UART_ADDR;
  assign rd_clk = !cpu_wr && a == IO_CLK_ADDR;
  assign wr_clk = wr_ok && a == IO_CLK_ADDR;
  assign in_pop = rd_uart && !in_empty;
  assign out_push = wr_clk || (wr_ok && a == IO_UART_ADDR && cpu_dout != 8'h00);
  assign out_din = wr_clk ? 8'h00 : cpu_dout;
  assign rx_ready = !in_full;
  assign tx_valid = !out_empty;
  // two free slots required so a write issued as rdy_out drops still fits
  assign rdy_out = !halted && out_count <= OCW'(OUT_DEPTH - 2);
  byte_fifo #(.DEPTH(IN_DEPTH)) u_in (
    .clk(clk_in), .rst(rst_in), .push(rx_valid), .pop(in_pop), .din(rx_data),
    .dout(in_head), .full(in_full), .empty(in_empty), .count(unused_in_count)
  );
  byte_fifo #(.DEPTH(OUT_DEPTH)) u_out (
    .clk(clk_in), .rst(rst_in), .push(out_push), .pop(tx_ready), .din(out_din),
    .dout(tx_data), .full(out_full), .empty(out_empty), .count(out_count)
  );
  // io read mux; the uart head is already 0 when the input FIFO is empty
  always_comb begin
    io_rd = a == IO_UART_ADDR ? in_head :
            a == IO_CLK_ADDR ? counter[7:0] :
            a == IO_CLK_ADDR + 18'd1 ? snap[7:0] :
            a == IO_CLK_ADDR + 18'd2 ? snap[15:8] :
            a == IO_CLK_ADDR + 18'd3 ? snap[23:16] : 8'h00;
  end
  // RAM write port, contents survive reset
  always_ff @(posedge clk_in) begin
    if (wr_ok && !io) mem[a[RAM_AW-1:0]] <= cpu_dout;
  end
  // registered read data, one cycle after the address
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cpu_din <= 8'h00;
    else cpu_din <= io ? io_rd : mem[a[RAM_AW-1:0]];
  end
  // free-running counter, snapshot on low-byte read, sticky halt and overflow flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      counter <= '0;
      snap <= '0;
      halted <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      counter <= counter + 32'd1;
      if (rd_clk) snap <= counter[31:8];
      if (wr_clk) halted <= 1'b1;
      if (out_push && out_full) tx_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [31:0] cpu_a = '0;
  logic [7:0] cpu_dout = '0;
  logic cpu_wr = 1'b0;
  logic [7:0] cpu_din;
  logic rdy_out;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready = 1'b0;
  logic halted;
  logic tx_ovf;
  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;
  logic [31:0] e;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .rdy_out(rdy_out), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halted(halted), .tx_ovf(tx_ovf)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] adr, input logic [7:0] d, input logic w);
    cpu_a = adr;
    cpu_dout = d;
    cpu_wr = w;
    @(posedge clk_in);
    #1;
    edges++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_din"}, 32'(cpu_din), 32'h0);
    chk({tag, "_rdy"}, 32'(rdy_out), 32'h1);
    chk({tag, "_rxrdy"}, 32'(rx_ready), 32'h1);
    chk({tag, "_txv"}, 32'(tx_valid), 32'h0);
    chk({tag, "_txd"}, 32'(tx_data), 32'h0);
    chk({tag, "_halt"}, 32'(halted), 32'h0);
    chk({tag, "_ovf"}, 32'(tx_ovf), 32'h0);
  endtask

  initial begin
    #12;
    chk_reset("reset");
    @(negedge clk_in);
    rst_in = 1'b0;
    edges = 0;
    step(32'h10, 8'hA5, 1'b1);
    step(32'h10, 8'h00, 1'b0);
    chk("ram_rd", 32'(cpu_din), 32'hA5);
    step(32'h1FFFF, 8'h3C, 1'b1);
    step(32'h1FFFF, 8'h00, 1'b0);
    chk("ram_top", 32'(cpu_din), 32'h3C);
    step(32'h20010, 8'h00, 1'b0);
    chk("ram_alias", 32'(cpu_din), 32'hA5);
    rx_valid = 1'b1;
    rx_data = 8'h41;
    step(32'h0, 8'h00, 1'b0);
    rx_data = 8'h42;
    step(32'h0, 8'h00, 1'b0);
    rx_valid = 1'b0;
    chk("rx_ready", 32'(rx_ready), 32'h1);
    step(32'h30000, 8'h00, 1'b0);
    chk("uart_rd0", 32'(cpu_din), 32'h41);
    step(32'h30000, 8'h00, 1'b0);
    chk("uart_rd1", 32'(cpu_din), 32'h42);
    step(32'h30000, 8'h00, 1'b0);
    chk("uart_rd_empty", 32'(cpu_din), 32'h00);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    step(32'h30000, 8'h00, 1'b0);
    rx_valid = 1'b0;
    chk("uart_race_din", 32'(cpu_din), 32'h00);
    step(32'h30000, 8'h00, 1'b0);
    chk("uart_race_kept", 32'(cpu_din), 32'h55);
    step(32'h30001, 8'h00, 1'b0);
    chk("io_other", 32'(cpu_din), 32'h00);
    tx_ready = 1'b1;
    step(32'h30000, 8'h48, 1'b1);
    chk("tx_v0", 32'(tx_valid), 32'h1);
    chk("tx_d0", 32'(tx_data), 32'h48);
    step(32'h30000, 8'h00, 1'b1);
    chk("tx_zero_drop", 32'(tx_valid), 32'h0);
    step(32'h30000, 8'h69, 1'b1);
    chk("tx_d1", 32'(tx_data), 32'h69);
    step(32'h0, 8'h00, 1'b0);
    chk("tx_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    for (int i = 1; i <= 14; i++) step(32'h30000, 8'(i), 1'b1);
    chk("rdy_at14", 32'(rdy_out), 32'h1);
    step(32'h30000, 8'd15, 1'b1);
    chk("rdy_at15", 32'(rdy_out), 32'h0);
    step(32'h30000, 8'd16, 1'b1);
    chk("ovf_at16", 32'(tx_ovf), 32'h0);
    step(32'h30000, 8'd17, 1'b1);
    chk("ovf_at17", 32'(tx_ovf), 32'h1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(tx_data), 32'(i));
      step(32'h0, 8'h00, 1'b0);
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    chk("rdy_back", 32'(rdy_out), 32'h1);
    while (edges < 300) step(32'h0, 8'h00, 1'b0);
    e = 32'(edges);
    step(32'h30004, 8'h00, 1'b0);
    chk("cnt_b0", 32'(cpu_din), 32'(e[7:0]));
    step(32'h30005, 8'h00, 1'b0);
    chk("cnt_b1", 32'(cpu_din), 32'(e[15:8]));
    step(32'h30006, 8'h00, 1'b0);
    chk("cnt_b2", 32'(cpu_din), 32'(e[23:16]));
    step(32'h30007, 8'h00, 1'b0);
    chk("cnt_b3", 32'(cpu_din), 32'(e[31:24]));
    step(32'h30004, 8'h77, 1'b1);
    chk("halt", 32'(halted), 32'h1);
    chk("halt_rdy", 32'(rdy_out), 32'h0);
    chk("halt_txv", 32'(tx_valid), 32'h1);
    chk("halt_txd", 32'(tx_data), 32'h00);
    step(32'h10, 8'h11, 1'b1);
    chk("halt_popped", 32'(tx_valid), 32'h0);
    step(32'h30000, 8'h50, 1'b1);
    chk("halt_io_wr", 32'(tx_valid), 32'h0);
    step(32'h10, 8'h00, 1'b0);
    chk("halt_ram_wr", 32'(cpu_din), 32'hA5);
    rx_valid = 1'b1;
    rx_data = 8'h99;
    step(32'h0, 8'h00, 1'b0);
    rx_valid = 1'b0;
    rst_in = 1'b1;
    #1;
    chk_reset("midreset");
    @(negedge clk_in);
    rst_in = 1'b0;
    edges = 0;
    for (int i = 0; i < 5; i++) step(32'h0, 8'h00, 1'b0);
    step(32'h30004, 8'h00, 1'b0);
    chk("cnt_restart", 32'(cpu_din), 32'd5);
    step(32'h30000, 8'h00, 1'b0);
    chk("in_flushed", 32'(cpu_din), 32'h00);
    step(32'h10, 8'h00, 1'b0);
    chk("ram_kept", 32'(cpu_din), 32'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
